dma_copy: RTL and testbench



---
 rtl/dma_copy.sv | 170 +++++++++++++++++
 tb/tb_dma_copy.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy.sv
// dma_copy: block-transfer engine driving a simple dual-port RAM.
//   COPY moves `length` words from src to dst through a one-word pipeline.
//   FILL writes `fill_val` to `length` words starting at dst.
//   RAM enables are combinational and gated by bus_grant.
// Ports:
//   clk, rst (async, active-low)
//   start, mode, src_addr, dst_addr, length, fill_val : transfer request
//   bus_grant : RAM ownership for this cycle
//   busy, done : status (done is a one-cycle pulse)
//   ram_r_addr/ram_r_en/ram_dout : registered read port
//   ram_w_addr/ram_w_en/ram_din  : write port
module dma_copy #(
  parameter int unsigned addr_width = 12,
  parameter int unsigned data_width = 8,
  parameter int unsigned len_width  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [addr_width-1:0] src_addr,
  input  logic [addr_width-1:0] dst_addr,
  input  logic [len_width-1:0]  length,
  input  logic [data_width-1:0] fill_val,
  input  logic                  bus_grant,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] ram_r_addr,
  output logic                  ram_r_en,
  input  logic [data_width-1:0] ram_dout,
  output logic [addr_width-1:0] ram_w_addr,
  output logic                  ram_w_en,
  output logic [data_width-1:0] ram_din
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [addr_width-1:0] src_q, src_d;
  logic [addr_width-1:0] dst_q, dst_d;
  logic [len_width-1:0]  len_q, len_d;
  logic [data_width-1:0] fill_q, fill_d;
  logic [len_width-1:0]  rd_cnt_q, rd_cnt_d;
  logic [len_width-1:0]  wr_cnt_q, wr_cnt_d;
  // rd_pend: a read was issued last cycle, so ram_dout carries a word now
  logic                  rd_pend_q, rd_pend_d;
  // hold: word parked while the bus was withdrawn
  logic                  hold_vld_q, hold_vld_d;
  logic [data_width-1:0] hold_q, hold_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      fill_q     <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rd_pend_q  <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_pend_q  <= rd_pend_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end

  // Next-state and RAM port control
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    fill_d     = fill_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_pend_d  = 1'b0;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    ram_r_en   = 1'b0;
    ram_r_addr = '0;
    ram_w_en   = 1'b0;
    ram_w_addr = '0;
    ram_din    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          src_d      = src_addr;
          dst_d      = dst_addr;
          len_d      = length;
          fill_d     = fill_val;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
          hold_vld_d = 1'b0;
          state_d    = (length == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN, S_FLUSH: begin
        if (mode_q) begin
          if (bus_grant) begin
            ram_w_en   = 1'b1;
            ram_w_addr = dst_q + addr_width'(wr_cnt_q);
            ram_din    = fill_q;
            wr_cnt_d   = wr_cnt_q + len_width'(1);
          end
          if (wr_cnt_d == len_q) state_d = S_DONE;
        end else begin
          if (bus_grant) begin
            if (hold_vld_q) begin
              // Drain the parked word; the read slot is given up this cycle
              ram_w_en   = 1'b1;
              ram_w_addr = dst_q + addr_width'(wr_cnt_q);
              ram_din    = hold_q;
              wr_cnt_d   = wr_cnt_q + len_width'(1);
              hold_vld_d = 1'b0;
            end else begin
              if (rd_pend_q) begin
                ram_w_en   = 1'b1;
                ram_w_addr = dst_q + addr_width'(wr_cnt_q);
                ram_din    = ram_dout;
                wr_cnt_d   = wr_cnt_q + len_width'(1);
              end
              if (rd_cnt_q < len_q) begin
                ram_r_en   = 1'b1;
                ram_r_addr = src_q + addr_width'(rd_cnt_q);
                rd_cnt_d   = rd_cnt_q + len_width'(1);
                rd_pend_d  = 1'b1;
              end
            end
          end else if (rd_pend_q) begin
            hold_d     = ram_dout;
            hold_vld_d = 1'b1;
          end
          if (state_q == S_RUN && rd_cnt_d == len_q) state_d = S_FLUSH;
          if (state_q == S_FLUSH && wr_cnt_d == len_q) state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: self-checking bench for dma_copy with a behavioural RAM and
// a transfer-level reference (k-th write goes to dst+k carrying src word k).
module tb_dma_copy;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 13;
  localparam int MAXC = 400;

  logic          clk, rst, start, mode, bus_grant;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] length;
  logic [DW-1:0] fill_val;
  logic          busy, done, ram_r_en, ram_w_en;
  logic [AW-1:0] ram_r_addr, ram_w_addr;
  logic [DW-1:0] ram_dout, ram_din;

  dma_copy #(.addr_width(AW), .data_width(DW), .len_width(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_val(fill_val), .bus_grant(bus_grant), .busy(busy), .done(done),
    .ram_r_addr(ram_r_addr), .ram_r_en(ram_r_en), .ram_dout(ram_dout),
    .ram_w_addr(ram_w_addr), .ram_w_en(ram_w_en), .ram_din(ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read, read-before-write on the same address
  logic [DW-1:0] mem [0:4095];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  always @(posedge clk) begin
    if (ram_r_en) ram_dout <= mem[ram_r_addr];
    if (ram_w_en) mem[ram_w_addr] <= ram_din;
    if (pre_en) mem[pre_addr] <= pre_data;
  end

  int n_checks, n_pass;
  bit grant_plan [0:MAXC];
  bit busy_log [0:MAXC];
  int inject_cyc, done_cyc, done_cnt, ng_access, last_cyc;
  logic [AW-1:0] wa_q[$], ra_q[$];
  logic [DW-1:0] wd_q[$];
  int wc_q[$], rc_q[$];
  logic [DW-1:0] src_vals [0:63];

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1 pre_en = 1'b0;
  endtask

  task automatic grant_all;
    for (int c = 0; c <= MAXC; c++) grant_plan[c] = 1'b1;
  endtask

  // Run one transfer and record every RAM access, busy and done per cycle.
  // Cycle c is the clock period following edge c-1; start is sampled at edge 0.
  task automatic xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                      input logic [LW-1:0] l, input logic [DW-1:0] f);
    wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete(); rc_q.delete();
    done_cyc = -1; done_cnt = 0; ng_access = 0; last_cyc = 0;
    mode = m; src_addr = s; dst_addr = d; length = l; fill_val = f;
    start = 1'b1; bus_grant = 1'b1;
    @(posedge clk);
    for (int c = 1; c < MAXC; c++) begin
      #1;
      bus_grant = grant_plan[c];
      if (c == inject_cyc) begin
        start = 1'b1; mode = ~m; dst_addr = d + 12'h100; length = l + 13'd1;
      end else start = 1'b0;
      @(negedge clk);
      last_cyc = c;
      busy_log[c] = busy;
      if (!bus_grant && (ram_r_en || ram_w_en)) ng_access++;
      if (ram_r_en) begin ra_q.push_back(ram_r_addr); rc_q.push_back(c); end
      if (ram_w_en) begin
        wa_q.push_back(ram_w_addr); wd_q.push_back(ram_din); wc_q.push_back(c);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk);
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
    end
    #1 start = 1'b0; bus_grant = 1'b1;
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if ({busy, done, ram_r_en, ram_w_en} !== 4'b0)
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, ram_r_en, ram_w_en});
    else n_pass++;
    n_checks++;
    if ({ram_r_addr, ram_w_addr, ram_din} !== '0)
      $display("FAIL reset_buses: got %h expected 0", {ram_r_addr, ram_w_addr, ram_din});
    else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_copy_basic;
    logic [DW-1:0] v [0:3];
    v[0] = 8'hA1; v[1] = 8'hB2; v[2] = 8'hC3; v[3] = 8'hD4;
    for (int k = 0; k < 4; k++) preload(12'h010 + AW'(k), v[k]);
    grant_all();
    xfer(1'b0, 12'h010, 12'h200, 13'd4, 8'h00);
    n_checks++;
    if (wa_q.size() != 4) $display("FAIL copy_nwrites: got %0d expected 4", wa_q.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
      n_checks++;
      if ({wa_q[k], wd_q[k]} !== {12'h200 + AW'(k), v[k]} || wc_q[k] != k + 2)
        $display("FAIL copy_write%0d: got %h/%h@%0d expected %h/%h@%0d", k,
                 wa_q[k], wd_q[k], wc_q[k], 12'h200 + AW'(k), v[k], k + 2);
      else n_pass++;
    end
    for (int k = 0; k < 4 && k < ra_q.size(); k++) begin
      n_checks++;
      if (ra_q[k] !== 12'h010 + AW'(k) || rc_q[k] != k + 1)
        $display("FAIL copy_read%0d: got %h@%0d expected %h@%0d", k, ra_q[k], rc_q[k],
                 12'h010 + AW'(k), k + 1);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc != 6 || done_cnt != 1)
      $display("FAIL copy_done: got cycle %0d count %0d expected cycle 6 count 1", done_cyc, done_cnt);
    else n_pass++;
    for (int c = 1; c <= last_cyc; c++) begin
      n_checks++;
      if (busy_log[c] !== (c <= 5))
        $display("FAIL copy_busy_c%0d: got %b expected %b", c, busy_log[c], (c <= 5));
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mem[12'h200 + AW'(k)] !== v[k])
        $display("FAIL copy_mem%0d: got %h expected %h", k, mem[12'h200 + AW'(k)], v[k]);
      else n_pass++;
    end
  endtask

  task automatic test_fill;
    grant_all();
    xfer(1'b1, 12'h000, 12'h0FE, 13'd4, 8'h5A);
    n_checks++;
    if (wa_q.size() != 4 || ra_q.size() != 0)
      $display("FAIL fill_counts: got w%0d r%0d expected w4 r0", wa_q.size(), ra_q.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
      n_checks++;
      if ({wa_q[k], wd_q[k]} !== {12'h0FE + AW'(k), 8'h5A} || wc_q[k] != k + 1)
        $display("FAIL fill_write%0d: got %h/%h@%0d expected %h/5a@%0d", k,
                 wa_q[k], wd_q[k], wc_q[k], 12'h0FE + AW'(k), k + 1);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc != 5 || done_cnt != 1)
      $display("FAIL fill_done: got cycle %0d count %0d expected cycle 5 count 1", done_cyc, done_cnt);
    else n_pass++;
  endtask

  task automatic test_grant_stall;
    for (int k = 0; k < 6; k++) begin
      src_vals[k] = DW'($urandom);
      preload(12'h300 + AW'(k), src_vals[k]);
    end
    grant_all();
    grant_plan[2] = 1'b0; grant_plan[3] = 1'b0; grant_plan[4] = 1'b0;
    xfer(1'b0, 12'h300, 12'h700, 13'd6, 8'h00);
    grant_all();
    n_checks++;
    if (ng_access != 0) $display("FAIL stall_no_access: got %0d accesses expected 0", ng_access);
    else n_pass++;
    n_checks++;
    if (wc_q.size() < 1 || wc_q[0] != 5 || wd_q[0] !== src_vals[0])
      $display("FAIL stall_held_first: got %0d writes first@%0d expected held word at cycle 5",
               wc_q.size(), (wc_q.size() > 0) ? wc_q[0] : -1);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (mem[12'h700 + AW'(k)] !== src_vals[k])
        $display("FAIL stall_mem%0d: got %h expected %h", k, mem[12'h700 + AW'(k)], src_vals[k]);
      else n_pass++;
    end
    // Three stalled cycles, plus the read slot spent writing the held word.
    n_checks++;
    if (done_cyc != 6 + 2 + 3 + 1)
      $display("FAIL stall_done: got cycle %0d expected cycle %0d", done_cyc, 12);
    else n_pass++;
  endtask

  task automatic test_wrap;
    logic [AW-1:0] ra_exp [0:2];
    ra_exp[0] = 12'hFFE; ra_exp[1] = 12'hFFF; ra_exp[2] = 12'h000;
    for (int k = 0; k < 3; k++) begin
      src_vals[k] = DW'($urandom);
      preload(ra_exp[k], src_vals[k]);
    end
    grant_all();
    xfer(1'b0, 12'hFFE, 12'h000, 13'd3, 8'h00);
    n_checks++;
    if (ra_q.size() != 3) $display("FAIL wrap_nreads: got %0d expected 3", ra_q.size());
    else n_pass++;
    for (int k = 0; k < 3 && k < ra_q.size(); k++) begin
      n_checks++;
      if (ra_q[k] !== ra_exp[k]) $display("FAIL wrap_read%0d: got %h expected %h", k, ra_q[k], ra_exp[k]);
      else n_pass++;
    end
    for (int k = 0; k < 2 && k < wa_q.size(); k++) begin
      n_checks++;
      if ({wa_q[k], wd_q[k]} !== {AW'(k), src_vals[k]})
        $display("FAIL wrap_write%0d: got %h/%h expected %h/%h", k, wa_q[k], wd_q[k], AW'(k), src_vals[k]);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc != 5) $display("FAIL wrap_done: got cycle %0d expected 5", done_cyc);
    else n_pass++;
  endtask

  task automatic test_len0;
    grant_all();
    xfer(1'b0, 12'h123, 12'h456, 13'd0, 8'h00);
    n_checks++;
    if (done_cyc != 1 || done_cnt != 1)
      $display("FAIL len0_done: got cycle %0d count %0d expected cycle 1 count 1", done_cyc, done_cnt);
    else n_pass++;
    n_checks++;
    if (ra_q.size() != 0 || wa_q.size() != 0 || busy_log[1] !== 1'b0)
      $display("FAIL len0_quiet: got r%0d w%0d busy %b expected r0 w0 busy 0",
               ra_q.size(), wa_q.size(), busy_log[1]);
    else n_pass++;
  endtask

  task automatic test_reset_abort;
    int stray;
    for (int k = 0; k < 8; k++) begin
      src_vals[k] = DW'($urandom_range(0, 8'hDF));
      preload(12'h500 + AW'(k), src_vals[k]);
      preload(12'h900 + AW'(k), 8'hEE);
    end
    mode = 1'b0; src_addr = 12'h500; dst_addr = 12'h900; length = 13'd8; bus_grant = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, ram_r_en, ram_w_en, ram_r_addr, ram_w_addr, ram_din} !== '0)
      $display("FAIL abort_outputs: got %b%b%b%b %h %h %h expected all zero",
               busy, done, ram_r_en, ram_w_en, ram_r_addr, ram_w_addr, ram_din);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ram_w_en || ram_r_en || busy || done) stray++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (stray != 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", stray);
    else n_pass++;
    n_checks++;
    if (mem[12'h900] !== src_vals[0]) $display("FAIL abort_first: got %h expected %h", mem[12'h900], src_vals[0]);
    else n_pass++;
    for (int k = 1; k < 8; k++) begin
      n_checks++;
      if (mem[12'h900 + AW'(k)] !== 8'hEE)
        $display("FAIL abort_untouched%0d: got %h expected ee", k, mem[12'h900 + AW'(k)]);
      else n_pass++;
    end
    grant_all();
    xfer(1'b0, 12'h500, 12'h980, 13'd3, 8'h00);
    n_checks++;
    if (done_cyc != 5 || wa_q.size() != 3) $display("FAIL abort_restart: got done %0d writes %0d expected done 5 writes 3", done_cyc, wa_q.size());
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (mem[12'h980 + AW'(k)] !== src_vals[k])
        $display("FAIL abort_restart_mem%0d: got %h expected %h", k, mem[12'h980 + AW'(k)], src_vals[k]);
      else n_pass++;
    end
  endtask

  task automatic test_start_busy;
    for (int k = 0; k < 10; k++) begin
      src_vals[k] = DW'($urandom);
      preload(12'h600 + AW'(k), src_vals[k]);
    end
    grant_all();
    inject_cyc = 4;
    xfer(1'b0, 12'h600, 12'hB00, 13'd10, 8'h00);
    inject_cyc = -1;
    n_checks++;
    if (done_cnt != 1 || done_cyc != 12)
      $display("FAIL busy_start_done: got count %0d cycle %0d expected count 1 cycle 12", done_cnt, done_cyc);
    else n_pass++;
    n_checks++;
    if (wa_q.size() != 10) $display("FAIL busy_start_nwrites: got %0d expected 10", wa_q.size());
    else n_pass++;
    for (int k = 0; k < 10 && k < wa_q.size(); k++) begin
      n_checks++;
      if ({wa_q[k], wd_q[k]} !== {12'hB00 + AW'(k), src_vals[k]})
        $display("FAIL busy_start_write%0d: got %h/%h expected %h/%h", k, wa_q[k], wd_q[k],
                 12'hB00 + AW'(k), src_vals[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      logic          m;
      int            l, bad_busy, bad_w, bad_r;
      logic [AW-1:0] s, d;
      logic [DW-1:0] f;
      m = 1'($urandom_range(0, 1));
      l = $urandom_range(1, 40);
      s = 12'h400 + AW'($urandom_range(0, 12'h3FF));
      d = ($urandom_range(0, 1) == 0) ? 12'hA00 + AW'($urandom_range(0, 12'h1FF))
                                      : s - AW'($urandom_range(0, l));
      f = DW'($urandom);
      for (int k = 0; k < l; k++) begin
        src_vals[k] = DW'($urandom);
        preload(s + AW'(k), src_vals[k]);
      end
      for (int c = 0; c <= MAXC; c++) grant_plan[c] = ($urandom_range(0, 3) != 0);
      xfer(m, s, d, LW'(l), f);
      grant_all();
      bad_w = 0; bad_r = 0; bad_busy = 0;
      for (int k = 0; k < wa_q.size() && k < l; k++)
        if ({wa_q[k], wd_q[k]} !== {d + AW'(k), m ? f : src_vals[k]}) bad_w++;
      for (int k = 0; k < ra_q.size() && k < l; k++)
        if (ra_q[k] !== s + AW'(k)) bad_r++;
      for (int c = 1; c <= last_cyc; c++)
        if (busy_log[c] !== (done_cyc > 0 && c < done_cyc)) bad_busy++;
      n_checks++;
      if (ng_access != 0 || done_cnt != 1)
        $display("FAIL rand%0d_handshake: got %0d ungranted accesses %0d dones expected 0 and 1", it, ng_access, done_cnt);
      else n_pass++;
      n_checks++;
      if (wa_q.size() != l || ra_q.size() != (m ? 0 : l))
        $display("FAIL rand%0d_counts: got w%0d r%0d expected w%0d r%0d", it, wa_q.size(), ra_q.size(), l, m ? 0 : l);
      else n_pass++;
      n_checks++;
      if (bad_w != 0 || bad_r != 0)
        $display("FAIL rand%0d_accesses: got %0d bad writes %0d bad reads expected 0", it, bad_w, bad_r);
      else n_pass++;
      n_checks++;
      if (bad_busy != 0) $display("FAIL rand%0d_busy: got %0d bad cycles expected 0", it, bad_busy);
      else n_pass++;
      for (int k = 0; k < l; k++) begin
        n_checks++;
        if (mem[d + AW'(k)] !== (m ? f : src_vals[k]))
          $display("FAIL rand%0d_mem%0d: got %h expected %h", it, k, mem[d + AW'(k)], m ? f : src_vals[k]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b0; start = 1'b0; mode = 1'b0; bus_grant = 1'b1;
    src_addr = '0; dst_addr = '0; length = '0; fill_val = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    inject_cyc = -1;
    grant_all();
    test_reset();
    test_copy_basic();
    test_fill();
    test_grant_stall();
    test_wrap();
    test_len0();
    test_reset_abort();
    test_start_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
